// File: rtl/game_sequencer.sv
// Round sequencer for the scrambled-number sum game: fetches two operands per round
// from the number ROM, grades the player's sum under a timeout and keeps score.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for access_granted; all outputs cleared
// FETCH_A  | rom_addr holds operand A address, ROM sampling it
// WAIT_A   | rom_q carries operand A, captured into num_a
// FETCH_B  | rom_addr holds operand B address, ROM sampling it
// WAIT_B   | rom_q carries operand B, captured into num_b; arm timeout
// PLAY     | waiting for button_pulse or timer expiry
// CHECK    | grade the latched guess against num_a + num_b
// RESULT   | hold correct/wrong LED for RESULT_CYC cycles
// DONE     | game over; score and operands held until access drops
module game_sequencer #(
   parameter int ROUNDS     = 4,
   parameter int BASE_ADDR  = 0,
   parameter int TIMEOUT    = 100,
   parameter int RESULT_CYC = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       access_granted,
   input  logic       button_pulse,
   input  logic [3:0] toggle_switch,
   output logic [3:0] rom_addr,
   input  logic [3:0] rom_q,
   output logic [3:0] num_a,
   output logic [3:0] num_b,
   output logic [3:0] score,
   output logic [3:0] round,
   output logic       correct_led,
   output logic       wrong_led,
   output logic       game_over,
   output logic       busy
);

   localparam int TMR_MAX = (TIMEOUT > RESULT_CYC) ? TIMEOUT : RESULT_CYC;
   localparam int TW      = $clog2(TMR_MAX + 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH_A,
      S_WAIT_A,
      S_FETCH_B,
      S_WAIT_B,
      S_PLAY,
      S_CHECK,
      S_RESULT,
      S_DONE
   } state_t;

   state_t        state, state_n;
   logic [3:0]    rom_addr_n, num_a_n, num_b_n, score_n, round_n;
   logic [3:0]    guess, guess_n;
   logic          to_flag, to_flag_n;
   logic          correct_n, wrong_n;
   logic [TW-1:0] tmr, tmr_n;
   logic [3:0]    sum4, addr_a, addr_a_next;

   // 4-bit add: the carry out of the operand sum is deliberately dropped
   assign sum4        = num_a + num_b;
   assign addr_a      = 4'(BASE_ADDR) + (round << 1);
   assign addr_a_next = 4'(BASE_ADDR) + ((round + 4'd1) << 1);

   assign busy      = (state != S_IDLE) && (state != S_DONE);
   assign game_over = (state == S_DONE);

   always_comb begin
      state_n    = state;
      rom_addr_n = rom_addr;
      num_a_n    = num_a;
      num_b_n    = num_b;
      score_n    = score;
      round_n    = round;
      guess_n    = guess;
      to_flag_n  = to_flag;
      correct_n  = correct_led;
      wrong_n    = wrong_led;
      tmr_n      = tmr;

      case (state)
         S_IDLE: begin
            if (access_granted) begin
               state_n    = S_FETCH_A;
               rom_addr_n = 4'(BASE_ADDR);
               round_n    = 4'd0;
            end
         end
         S_FETCH_A: state_n = S_WAIT_A;
         S_WAIT_A: begin
            num_a_n    = rom_q;
            rom_addr_n = addr_a + 4'd1;
            state_n    = S_FETCH_B;
         end
         S_FETCH_B: state_n = S_WAIT_B;
         S_WAIT_B: begin
            num_b_n   = rom_q;
            tmr_n     = TW'(TIMEOUT);
            to_flag_n = 1'b0;
            state_n   = S_PLAY;
         end
         S_PLAY: begin
            // a press on the expiry cycle takes priority over the timeout
            if (button_pulse) begin
               guess_n = toggle_switch;
               state_n = S_CHECK;
            end else begin
               tmr_n = tmr - TW'(1);
               if (tmr == TW'(1)) begin
                  to_flag_n = 1'b1;
                  state_n   = S_CHECK;
               end
            end
         end
         S_CHECK: begin
            tmr_n   = TW'(RESULT_CYC);
            state_n = S_RESULT;
            if (!to_flag && (guess == sum4)) begin
               correct_n = 1'b1;
               score_n   = score + 4'd1;
            end else begin
               wrong_n = 1'b1;
            end
         end
         S_RESULT: begin
            tmr_n = tmr - TW'(1);
            if (tmr == TW'(1)) begin
               correct_n = 1'b0;
               wrong_n   = 1'b0;
               if (round == 4'(ROUNDS - 1)) begin
                  state_n = S_DONE;
               end else begin
                  round_n    = round + 4'd1;
                  rom_addr_n = addr_a_next;
                  state_n    = S_FETCH_A;
               end
            end
         end
         S_DONE: state_n = S_DONE;
         default: state_n = S_IDLE;
      endcase

      // losing access aborts the game from anywhere, including DONE
      if ((state != S_IDLE) && !access_granted) begin
         state_n    = S_IDLE;
         rom_addr_n = 4'd0;
         num_a_n    = 4'd0;
         num_b_n    = 4'd0;
         score_n    = 4'd0;
         round_n    = 4'd0;
         correct_n  = 1'b0;
         wrong_n    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         rom_addr    <= 4'd0;
         num_a       <= 4'd0;
         num_b       <= 4'd0;
         score       <= 4'd0;
         round       <= 4'd0;
         guess       <= 4'd0;
         to_flag     <= 1'b0;
         correct_led <= 1'b0;
         wrong_led   <= 1'b0;
         tmr         <= '0;
      end else begin
         state       <= state_n;
         rom_addr    <= rom_addr_n;
         num_a       <= num_a_n;
         num_b       <= num_b_n;
         score       <= score_n;
         round       <= round_n;
         guess       <= guess_n;
         to_flag     <= to_flag_n;
         correct_led <= correct_n;
         wrong_led   <= wrong_n;
         tmr         <= tmr_n;
      end
   end

endmodule

// File: tb/tb_game_sequencer.sv
// Testbench for game_sequencer: ROM model, expected grades queued at each press
// and compared when the LED rises, plus cycle-exact timing checks.
module tb_game_sequencer;

   localparam int ROUNDS     = 4;
   localparam int BASE_ADDR  = 0;
   localparam int TIMEOUT    = 100;
   localparam int RESULT_CYC = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       access_granted;
   logic       button_pulse;
   logic [3:0] toggle_switch;
   logic [3:0] rom_addr;
   logic [3:0] rom_q = 4'd0;
   logic [3:0] num_a, num_b, score, round;
   logic       correct_led, wrong_led, game_over, busy;

   logic [3:0] rom [16];

   typedef struct {
      logic       correct;
      logic [3:0] score;
   } grade_t;

   grade_t sb[$];
   grade_t g;
   logic   led_prev = 1'b0;
   int     n_checks = 0;
   int     n_err    = 0;
   int     exp_score;

   game_sequencer #(
      .ROUNDS(ROUNDS), .BASE_ADDR(BASE_ADDR), .TIMEOUT(TIMEOUT), .RESULT_CYC(RESULT_CYC)
   ) dut (
      .clk(clk), .rst(rst), .access_granted(access_granted), .button_pulse(button_pulse),
      .toggle_switch(toggle_switch), .rom_addr(rom_addr), .rom_q(rom_q),
      .num_a(num_a), .num_b(num_b), .score(score), .round(round),
      .correct_led(correct_led), .wrong_led(wrong_led), .game_over(game_over), .busy(busy)
   );

   always #5 clk = ~clk;

   // synchronous ROM, one-cycle read latency
   always @(posedge clk) rom_q <= rom[rom_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // grade monitor: each LED rising edge consumes one expected result
   always @(negedge clk) begin
      if ((correct_led || wrong_led) && !led_prev) begin
         if (sb.size() == 0) begin
            chk("unexpected_grade", 1, 0);
         end else begin
            g = sb.pop_front();
            chk("grade_correct_led", 32'(correct_led), 32'(g.correct));
            chk("grade_wrong_led", 32'(wrong_led), 32'(!g.correct));
            chk("grade_score", 32'(score), 32'(g.score));
         end
      end
      led_prev = correct_led || wrong_led;
   end

   // precondition: just after the edge that entered FETCH_A for round r
   task automatic round_run(input int r, input bit press, input int delay, input logic [3:0] ans);
      int a, b;
      bit ok;
      a = int'(rom[BASE_ADDR + 2*r]);
      b = int'(rom[BASE_ADDR + 2*r + 1]);
      tick(); tick();
      chk("num_a_after_e2", 32'(num_a), 32'(a));
      tick();
      chk("rom_addr_b", 32'(rom_addr), 32'(BASE_ADDR + 2*r + 1));
      tick();
      chk("num_b_after_e4", 32'(num_b), 32'(b));
      chk("busy_in_play", 32'(busy), 1);
      if (press) begin
         repeat (delay) tick();
         toggle_switch = ans;
         button_pulse  = 1'b1;
         ok = (ans == 4'(a + b));
         if (ok) exp_score++;
         sb.push_back('{ok, 4'(exp_score)});
         tick();
         button_pulse = 1'b0;
         chk("led_off_in_check", 32'({correct_led, wrong_led}), 0);
      end else begin
         sb.push_back('{1'b0, 4'(exp_score)});
         repeat (TIMEOUT) tick();
         chk("led_off_at_timeout_check", 32'({correct_led, wrong_led}), 0);
      end
      tick();
      chk("led_on", 32'(correct_led | wrong_led), 1);
      for (int i = 1; i < RESULT_CYC; i++) begin
         tick();
         chk("led_hold", 32'(correct_led | wrong_led), 1);
      end
      tick();
      chk("led_drop", 32'({correct_led, wrong_led}), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst            = 1'b0;
      access_granted = 1'b0;
      button_pulse   = 1'b0;
      toggle_switch  = 4'd0;
      for (int i = 0; i < 16; i++) rom[i] = 4'(i) ^ 4'hA;
      rom[0] = 4'd3; rom[1] = 4'd5; rom[2] = 4'd9; rom[3] = 4'd9;
      rom[4] = 4'd9; rom[5] = 4'd9; rom[6] = 4'd7; rom[7] = 4'd1;

      #12;
      chk("reset_outputs", 32'({rom_addr, num_a, num_b, score, round,
                                correct_led, wrong_led, game_over, busy}), 0);
      @(posedge clk); #1 rst = 1'b1;
      tick();

      // press while IDLE is ignored
      button_pulse = 1'b1; tick(); button_pulse = 1'b0;
      chk("idle_press_busy", 32'(busy), 0);

      // game 1: three correct answers, one press on the expiry cycle
      access_granted = 1'b1;
      tick();
      chk("busy_after_e0", 32'(busy), 1);
      chk("rom_addr_after_e0", 32'(rom_addr), BASE_ADDR);
      exp_score = 0;
      round_run(0, 1'b1, 3, 4'd8);
      chk("round_after_r0", 32'(round), 1);
      chk("rom_addr_r1", 32'(rom_addr), BASE_ADDR + 2);
      chk("score_after_r0", 32'(score), 1);
      round_run(1, 1'b1, 0, 4'd2);
      round_run(2, 1'b1, 5, 4'd3);
      round_run(3, 1'b1, TIMEOUT - 1, 4'd8);
      chk("game_over", 32'(game_over), 1);
      chk("done_busy", 32'(busy), 0);
      chk("done_score", 32'(score), 3);
      chk("done_operands", 32'({num_a, num_b}), 32'({4'd7, 4'd1}));

      // press in DONE is ignored
      toggle_switch = 4'd0; button_pulse = 1'b1; tick(); button_pulse = 1'b0; tick();
      chk("done_press_score", 32'(score), 3);
      chk("done_press_state", 32'({game_over, correct_led, wrong_led}), 32'(3'b100));

      access_granted = 1'b0;
      tick();
      chk("drop_after_done", 32'({score, round, num_a, game_over, busy}), 0);

      // game 2: abort during WAIT_B of round 1
      access_granted = 1'b1;
      tick();
      exp_score = 0;
      round_run(0, 1'b1, 0, 4'd8);
      tick(); tick(); tick();
      access_granted = 1'b0;
      tick();
      chk("drop_wait_b", 32'({score, round, num_a, num_b, busy}), 0);

      // game 3: unanswered round, press ignored in RESULT, abort in RESULT
      access_granted = 1'b1;
      tick();
      chk("regrant_addr", 32'(rom_addr), BASE_ADDR);
      chk("regrant_round", 32'(round), 0);
      exp_score = 0;
      tick(); tick(); tick(); tick();
      sb.push_back('{1'b0, 4'd0});
      repeat (TIMEOUT) tick();
      chk("timeout_led_off", 32'({correct_led, wrong_led}), 0);
      tick();
      chk("timeout_wrong_led", 32'(wrong_led), 1);
      toggle_switch = 4'd8; button_pulse = 1'b1; tick(); button_pulse = 1'b0;
      chk("result_press_score", 32'(score), 0);
      chk("result_press_led", 32'({correct_led, wrong_led}), 32'(2'b01));
      tick();
      access_granted = 1'b0;
      tick();
      chk("drop_result", 32'({correct_led, wrong_led, busy, score, round, num_a, num_b}), 0);

      // game 4: asynchronous reset mid-PLAY
      access_granted = 1'b1;
      tick();
      tick(); tick(); tick(); tick();
      repeat (10) tick();
      chk("play_busy_pre_reset", 32'(busy), 1);
      #2 rst = 1'b0;
      #1;
      chk("async_reset_outputs", 32'({rom_addr, num_a, num_b, score, round,
                                      correct_led, wrong_led, game_over, busy}), 0);
      tick();
      chk("reset_held_outputs", 32'({rom_addr, num_a, num_b, busy}), 0);
      access_granted = 1'b0;
      rst = 1'b1;
      tick();

      chk("sb_empty", 32'(sb.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
